ysyx_23060096_imm_enc: RTL and testbench
========================================

YSYX_23060096_IMM_ENC -- requirements
Module: ysyx_23060096_imm_enc

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted when in_valid&&in_ready at a rising edge.
REQ-006 ext_op  input  3  format select: 000 I, 001 U, 010 S, 011 B, 100 J, 101-111 illegal.
REQ-007 imm  input  32  immediate value, byte offset for B/J.
REQ-008 base  input  32  instruction template supplying all non-immediate bits.
REQ-009 out_valid  output  1  encoded word present.
REQ-010 out_ready  input  1  consumer accepts when out_valid&&out_ready at a rising edge.
REQ-011 out_inst  output  32  encoded instruction.
REQ-012 out_err  output  1  immediate not representable, or illegal ext_op; travels with out_inst.
REQ-013 err_cnt  output  8  saturating count of accepted requests with err=1.

Function
REQ-014 SHALL form out_inst from base, replacing only the immediate field bits of the selected format, as REQ-015 to REQ-019 define.
REQ-015 I: inst[31:20]=imm[11:0].
REQ-016 U: inst[31:12]=imm[31:12].
REQ-017 S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
REQ-018 B: inst[31]=imm[12]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1]; inst[7]=imm[11].
REQ-019 J: inst[31]=imm[20]; inst[30:21]=imm[10:1]; inst[20]=imm[11]; inst[19:12]=imm[19:12].
REQ-020 For an illegal ext_op, the block SHALL output out_inst=base with err=1.
REQ-021 SHALL buffer results in a 2-entry FIFO with storage {inst, err}.
REQ-022 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries; it SHALL be registered, with no combinational path from out_ready.
REQ-023 Latency: a request accepted at edge N into an empty FIFO SHALL show out_valid=1 after edge N.
REQ-024 Throughput SHALL be 1 word per cycle when out_ready is held at 1.
REQ-025 Output order SHALL match acceptance order.
REQ-026 out_inst and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Count 1 with push and pop in the same cycle SHALL leave the count at 1 and present the new entry next.
REQ-028 Count 2 SHALL accept no push; a pop SHALL still occur.
REQ-029 Count 0 SHALL give out_valid=0, and out_ready SHALL be ignored.
REQ-030 The FIFO read and write pointers SHALL wrap modulo 2.
REQ-031 err_cnt SHALL increment on each accepted request whose err=1, and SHALL saturate at 8'hFF.

Reset
REQ-032 When rstn is low, the block SHALL asynchronously set out_valid=0, in_ready=0, FIFO count=0, both pointers=0, and err_cnt=0.
REQ-033 When rstn is low, the block SHALL drive out_inst=0 and out_err=0.
REQ-034 in_ready SHALL rise at the first clk edge after rstn deasserts.
REQ-035 Reset asserted mid-transfer SHALL discard all buffered entries, and no stale word SHALL appear after reset.

Configuration
REQ-036 Macro YSYX_23060096_IMM_ENC_RANGE_CHECK_EN SHALL control the range check.
REQ-037 With the macro defined: err SHALL be 1 for I/S when imm is not the sign-extension of imm[11:0].
REQ-038 With the macro defined: err SHALL be 1 for U when imm[11:0]!=0.
REQ-039 With the macro defined: err SHALL be 1 for B when imm[0]!=0 or imm is not the sign-extension of imm[12:0].
REQ-040 With the macro defined: err SHALL be 1 for J when imm[0]!=0 or imm is not the sign-extension of imm[20:0].
REQ-041 With the macro defined, out_inst SHALL still be encoded per REQ-014 (truncated fields) when err=1.
REQ-042 Without the macro, err SHALL be 1 only for an illegal ext_op, and no range logic SHALL be synthesized.

Verification
REQ-043 The bench SHALL drive ext_op=000, imm=32'hFFFFF800, base=32'h00000013, out_ready=1 -> out_inst=32'h80000013, out_err=0, one cycle after acceptance.
REQ-044 The bench SHALL drive ext_op=011, imm=32'hFFFFFFFC, base=32'h00000063 -> out_inst=32'hFE000EE3, out_err=0.
REQ-045 The bench SHALL drive ext_op=100, imm=32'h00000800, base=32'h0000006F -> out_inst=32'h0010006F.
REQ-046 The bench SHALL drive ext_op=000 with imm=32'h00000800, then ext_op=101 -> with the macro, two errors and err_cnt=2; without the macro, one error and err_cnt=1.
REQ-047 The bench SHALL hold out_ready=0 and push 3 requests -> in_ready=0 after the 2nd, the 3rd held off; then set out_ready=1 -> 3 words are delivered in order with stable data while stalled.
REQ-048 The bench SHALL fill the FIFO, assert rstn=0 for 1 cycle, then release -> out_valid=0 and err_cnt=0 immediately, no old word is emitted, and in_ready=1 after the next edge.

Source files
------------

// File: rtl/ysyx_23060096_imm_enc.sv
// ysyx_23060096_imm_enc: patches the immediate of a RISC-V instruction template
// (I/U/S/B/J formats) and queues the result in a 2-entry FIFO.
// Optional macro YSYX_23060096_IMM_ENC_RANGE_CHECK_EN adds a representability
// check on imm; without it only an illegal ext_op raises the error flag.
//
// Handshake: a request moves on a rising edge where in_valid && in_ready; a
// result moves on a rising edge where out_valid && out_ready. in_ready comes
// straight from a flop (no path from out_ready), and out_inst/out_err hold
// while out_valid is high and out_ready is low.
module ysyx_23060096_imm_enc (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ext_op,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  logic [31:0] encInst;
  logic        opErr;
  logic        rangeErr;
  logic        encErr;

  logic [32:0] fifoMem [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;
  logic [1:0]  nextCount;
  logic        inReadyQ;
  logic [7:0]  errCnt;
  logic        push;
  logic        pop;

  // Splice the format's immediate field into the template; unknown formats pass base through.
  always_comb begin
    encInst = base;
    opErr   = 1'b0;
    case (ext_op)
      3'b000: encInst[31:20] = imm[11:0];
      3'b001: encInst[31:12] = imm[31:12];
      3'b010: begin
        encInst[31:25] = imm[11:5];
        encInst[11:7]  = imm[4:0];
      end
      3'b011: begin
        encInst[31]    = imm[12];
        encInst[30:25] = imm[10:5];
        encInst[11:8]  = imm[4:1];
        encInst[7]     = imm[11];
      end
      3'b100: begin
        encInst[31]    = imm[20];
        encInst[30:21] = imm[10:1];
        encInst[20]    = imm[11];
        encInst[19:12] = imm[19:12];
      end
      default: opErr = 1'b1;
    endcase
  end

`ifdef YSYX_23060096_IMM_ENC_RANGE_CHECK_EN
  // imm fits a signed N-bit field when all bits from N-1 upward are equal.
  logic sext12Ok;
  logic sext13Ok;
  logic sext21Ok;
  assign sext12Ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13Ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext21Ok = (&imm[31:20]) | ~(|imm[31:20]);

  // Flag immediates that the selected format would truncate or misalign.
  always_comb begin
    rangeErr = 1'b0;
    case (ext_op)
      3'b000, 3'b010: rangeErr = ~sext12Ok;
      3'b001:         rangeErr = |imm[11:0];
      3'b011:         rangeErr = imm[0] | ~sext13Ok;
      3'b100:         rangeErr = imm[0] | ~sext21Ok;
      default:        rangeErr = 1'b0;
    endcase
  end
`else
  assign rangeErr = 1'b0;
`endif

  assign encErr = opErr | rangeErr;

  // in_ready is registered, so a push can only happen while a slot is free.
  assign push      = in_valid & inReadyQ;
  assign pop       = (count != 2'd0) & out_ready;
  assign nextCount = count + {1'b0, push} - {1'b0, pop};

  // FIFO storage, 1-bit pointers (wrap modulo 2), occupancy and error counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      count      <= 2'd0;
      inReadyQ   <= 1'b0;
      errCnt     <= 8'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= {encErr, encInst};
        wrPtr          <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count    <= nextCount;
      inReadyQ <= (nextCount != 2'd2);
      if (push && encErr && (errCnt != 8'hFF)) begin
        errCnt <= errCnt + 8'd1;
      end
    end
  end

  assign out_valid           = (count != 2'd0);
  assign {out_err, out_inst} = out_valid ? fifoMem[rdPtr] : 33'd0;
  assign in_ready            = inReadyQ;
  assign err_cnt             = errCnt;

endmodule

// File: tb/tb_ysyx_23060096_imm_enc.sv
// Self-checking bench for ysyx_23060096_imm_enc: directed cases followed by
// random traffic, compared against a bit-map reference model and an expected
// queue of {err, inst} words.
module tb_ysyx_23060096_imm_enc;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ext_op = 3'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] base = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  ysyx_23060096_imm_enc dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ext_op    (ext_op),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  logic [7:0]  err_cnt_exp = 8'd0;
  logic        ready_exp = 1'b0;
  logic        last_push = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef YSYX_23060096_IMM_ENC_RANGE_CHECK_EN
  localparam logic [7:0] ERR_AFTER_PAIR = 8'd2;
`else
  localparam logic [7:0] ERR_AFTER_PAIR = 8'd1;
`endif

  // ---------------- reference model ----------------
  // Which imm bit lands in instruction bit p for a format; -1 keeps base.
  function automatic int src_bit(input logic [2:0] op, input int p);
    case (op)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: return (p >= 12) ? p : -1;
      3'd2: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
        return -1;
      end
      3'd3: begin
        if (p == 31) return 12;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      3'd4: begin
        if (p == 31) return 20;
        if (p >= 21) return p - 20;
        if (p == 20) return 11;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] v,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    longint      s;
    int          src;
    r = b;
    e = 1'b0;
    s = longint'($signed(v));
    if (op > 3'd4) return {1'b1, b};
    for (int p = 0; p < 32; p++) begin
      src = src_bit(op, p);
      if (src >= 0) r[p] = v[src];
    end
`ifdef YSYX_23060096_IMM_ENC_RANGE_CHECK_EN
    case (op)
      3'd0, 3'd2: e = (s < -2048) || (s > 2047);
      3'd1:       e = (v % 4096) != 0;
      3'd3:       e = v[0] || (s < -4096) || (s > 4095);
      default:    e = v[0] || (s < -(64'sd1 << 20)) || (s >= (64'sd1 << 20));
    endcase
`else
    e = s < 0 && 1'b0;
`endif
    return {e, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check outputs at the falling edge, predict handshakes, then advance.
  task automatic cycle();
    logic do_pop;
    @(negedge clk);
    check("in_ready", in_ready, ready_exp);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("err_cnt", err_cnt, err_cnt_exp);
    if (exp_q.size() != 0) begin
      check("out_inst", out_inst, exp_q[0][31:0]);
      check("out_err", out_err, exp_q[0][32]);
    end
    last_push = in_valid && ready_exp;
    do_pop = (exp_q.size() != 0) && out_ready;
    if (do_pop) void'(exp_q.pop_front());
    if (last_push) begin
      exp_q.push_back(model(ext_op, imm, base));
      if (exp_q[exp_q.size()-1][32] && err_cnt_exp != 8'hFF) err_cnt_exp++;
    end
    @(posedge clk);
    #1;
    ready_exp = exp_q.size() < 2;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] v, input logic [31:0] b);
    ext_op = op;
    imm = v;
    base = b;
    in_valid = 1'b1;
    last_push = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (last_push) break;
    end
    if (!last_push) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", out_err, 1'b0);
    exp_q.delete();
    err_cnt_exp = 8'd0;
    ready_exp = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_valid", out_valid, 1'b0);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    cycle();
    check("ready_after_reset", in_ready, 1'b1);

    // Directed encodings, checked against fixed words one cycle after acceptance.
    out_ready = 1'b1;
    send(3'b000, 32'hFFFFF800, 32'h00000013);
    check("i_inst", out_inst, 32'h80000013);
    check("i_err", out_err, 1'b0);
    check("i_valid", out_valid, 1'b1);
    send(3'b011, 32'hFFFFFFFC, 32'h00000063);
    check("b_inst", out_inst, 32'hFE000EE3);
    check("b_err", out_err, 1'b0);
    send(3'b100, 32'h00000800, 32'h0000006F);
    check("j_inst", out_inst, 32'h0010006F);
    cycle();

    // Out-of-range I immediate followed by an illegal format.
    send(3'b000, 32'h00000800, 32'h00000013);
    send(3'b101, 32'h12345678, 32'h00000033);
    check("illegal_inst", out_inst, 32'h00000033);
    check("illegal_err", out_err, 1'b1);
    cycle();
    cycle();
    check("err_pair", err_cnt, ERR_AFTER_PAIR);

    // Back-pressure: two fill the FIFO, the third waits.
    out_ready = 1'b0;
    send(3'b000, 32'h00000001, 32'h00000013);
    send(3'b010, 32'h00000008, 32'h00000023);
    check("full_in_ready", in_ready, 1'b0);
    ext_op = 3'b001;
    imm = 32'hABCDE000;
    base = 32'h00000037;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_front", out_inst, 32'h00100013);
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cycle();
      if (last_push) break;
    end
    if (!last_push) check("third_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("drained", out_valid, 1'b0);

    // Reset while full: nothing stale may come out afterwards.
    out_ready = 1'b0;
    send(3'b000, 32'h00000123, 32'h00000013);
    send(3'b110, 32'h00000000, 32'h00000073);
    do_reset();
    out_ready = 1'b1;
    cycle();
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_valid", out_valid, 1'b0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      ext_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = $urandom;
      endcase
      base = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Counter saturation with illegal formats.
    in_valid = 1'b1;
    ext_op = 3'b111;
    for (int i = 0; i < 270; i++) begin
      base = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    check("err_cnt_sat", err_cnt, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
